// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: packs a big-endian byte stream into 32-bit words.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word check.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK   = 3'd3,
`endif
    DONE    = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] addr;
  logic [15:0] words_left;
  logic [1:0]  byte_cnt;
  logic [23:0] word_sr;
  logic        accept;
  logic [31:0] full_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  assign accept    = byte_valid && byte_ready;
  // The fourth byte completes the word combinationally so it can be registered straight into mem_data.
  assign full_word = {word_sr, byte_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= 32'd0;
      words_left <= 16'd0;
      byte_cnt   <= 2'd0;
      word_sr    <= 24'd0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_data   <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 32'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (num_words == 16'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else if ({1'b0, num_words} > MAX_W) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              words_left <= num_words;
              addr       <= BASE_ADDR;
              byte_cnt   <= 2'd0;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
              byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum       <= 32'd0;
`endif
              state      <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            word_sr  <= {word_sr[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= addr;
              mem_data   <= full_word;
              state      <= WRITE;
            end
          end
        end

        WRITE: begin
          addr       <= addr + 32'd4;
          words_left <= words_left - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum       <= csum ^ mem_data;
`endif
          if (words_left == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            byte_ready <= 1'b1;
            state      <= CHECK;
`else
            done       <= 1'b1;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            state      <= DONE;
`endif
          end else begin
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          // The trailing word is compared only, never written to memory.
          if (accept) begin
            word_sr  <= {word_sr[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              byte_ready <= 1'b0;
              if (full_word != csum) error <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              state    <= DONE;
            end
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes/done results are queued by stimulus,
// a negedge monitor pops and compares. Checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [15:0] num_words;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, busy, done, error, cpu_hold;
  logic [31:0] mem_addr, mem_data;

  imem_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_wr[$];
  logic exp_err[$];
  int   checks = 0;
  int   errors = 0;
  int   n_writes = 0;
  int   w0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      n_writes++;
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%08h data=%08h expected no write", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("write_addr", mem_addr, e.a);
        chk("write_data", mem_data, e.d);
        chk("hold_during_write", 32'(cpu_hold), 32'd1);
      end
    end
    if (!reset && done) begin
      if (exp_err.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual done=1 expected done=0");
      end else begin
        logic e;
        e = exp_err.pop_front();
        chk("done_error", 32'(error), 32'(e));
        chk("done_busy_hold_low", 32'({busy, cpu_hold}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout actual byte_ready=0 expected byte_ready=1 within 50 cycles");
    end else begin
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input bit expect_write);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && expect_write) exp_wr.push_back('{a: a, d: w});
      send_byte(w[31-8*i -: 8]);
    end
    if (expect_write) chk("we_one_cycle_after_4th", 32'(mem_we), 32'd1);
  endtask

  task automatic send_check(input logic [31:0] w);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(w, 32'd0, 1'b0);
`else
    if (w == 32'hFFFF_FFFF) tick();
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual done=0 expected done=1 within 100 cycles");
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_words = 16'd0; byte_in = 8'd0; byte_valid = 1'b0;
    tick(); tick();
    chk("reset_ctrl", 32'({byte_ready, mem_we, busy, done, error, cpu_hold}), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_data", mem_data, 32'd0);
    reset = 1'b0;
    tick();

    // Basic two-word load
    w0 = n_writes;
    exp_err.push_back(1'b0);
    do_start(16'd2);
    chk("hold_after_start", 32'({busy, cpu_hold, byte_ready}), 32'd7);
    send_word(32'h2008_0005, 32'h0000_0000, 1'b1);
    chk("hold_between_words", 32'(cpu_hold), 32'd1);
    send_word(32'hAC09_0004, 32'h0000_0004, 1'b1);
    send_check(32'h2008_0005 ^ 32'hAC09_0004);
    wait_done();
    chk("basic_write_count", 32'(n_writes - w0), 32'd2);

    // Stalled stream
    w0 = n_writes;
    exp_err.push_back(1'b0);
    do_start(16'd1);
    send_byte(8'h8C);
    send_byte(8'h0A);
    repeat (5) tick();
    chk("stall_no_premature_we", 32'(n_writes - w0), 32'd0);
    send_byte(8'h00);
    exp_wr.push_back('{a: 32'h0000_0000, d: 32'h8C0A_0008});
    send_byte(8'h08);
    chk("stall_we_latency", 32'(mem_we), 32'd1);
    send_check(32'h8C0A_0008);
    wait_done();
    chk("stall_write_count", 32'(n_writes - w0), 32'd1);

    // Bounds: zero words and oversize request
    w0 = n_writes;
    exp_err.push_back(1'b0);
    do_start(16'd0);
    wait_done();
    chk("zero_no_write", 32'(n_writes - w0), 32'd0);
    exp_err.push_back(1'b1);
    do_start(16'd65);
    wait_done();
    chk("oversize_error_sticky", 32'(error), 32'd1);
    chk("oversize_no_write", 32'(n_writes - w0), 32'd0);

    // Mid-load reset after the 6th byte
    w0 = n_writes;
    do_start(16'd3);
    chk("error_cleared_on_start", 32'(error), 32'd0);
    send_word(32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b1;
    tick();
    chk("midreset_ctrl", 32'({byte_ready, mem_we, busy, done, error, cpu_hold}), 32'd0);
    chk("midreset_addr", mem_addr, 32'd0);
    chk("midreset_data", mem_data, 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk("midreset_write_count", 32'(n_writes - w0), 32'd1);

    // Reset coincident with start
    reset = 1'b1; start = 1'b1; num_words = 16'd2;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    chk("reset_beats_start", 32'({busy, cpu_hold, byte_ready}), 32'd0);

    // Start during COLLECT is ignored
    w0 = n_writes;
    exp_err.push_back(1'b0);
    do_start(16'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    do_start(16'd9);
    send_byte(8'h03);
    exp_wr.push_back('{a: 32'h0000_0000, d: 32'h0102_0304});
    send_byte(8'h04);
    send_word(32'h0506_0708, 32'h0000_0004, 1'b1);
    send_check(32'h0102_0304 ^ 32'h0506_0708);
    wait_done();
    chk("ignored_start_write_count", 32'(n_writes - w0), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w0 = n_writes;
    exp_err.push_back(1'b0);
    do_start(16'd2);
    send_word(32'h1111_1111, 32'h0000_0000, 1'b1);
    send_word(32'h2222_2222, 32'h0000_0004, 1'b1);
    chk("check_hold", 32'(cpu_hold), 32'd1);
    send_word(32'h3333_3333, 32'h0000_0000, 1'b0);
    wait_done();
    chk("csum_good_error", 32'(error), 32'd0);
    chk("csum_good_writes", 32'(n_writes - w0), 32'd2);

    w0 = n_writes;
    exp_err.push_back(1'b1);
    do_start(16'd2);
    send_word(32'h1111_1111, 32'h0000_0000, 1'b1);
    send_word(32'h2222_2222, 32'h0000_0004, 1'b1);
    send_word(32'h3333_3330, 32'h0000_0000, 1'b0);
    wait_done();
    chk("csum_bad_error", 32'(error), 32'd1);
    chk("csum_bad_writes", 32'(n_writes - w0), 32'd2);
`endif

    repeat (3) tick();
    chk("write_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_err.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
